fetch_unit: RTL and testbench

Front-end fetch stage. It sits on the producer side of the instruction buffer: it reads instruction blocks from the instruction memory port, unpacks them into INST_PACKETs, and pushes them into the buffer through in_insts/num_accept. Each push is limited by the buffer's advertised open_entries. On a branch squash (br_en) it redirects the PC, discards staged and in-flight instructions, and pushes nothing that cycle.

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_stage_buf.sv | 76 +++++++
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and default sizes for the fetch front end.
package fetch_unit_pkg;

  localparam int unsigned INST_BUFF_DEPTH = 8;
  localparam int unsigned FETCH_WIDTH     = 2;
  localparam int unsigned MEM_TAG_W       = 4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic        valid;
  } INST_PACKET;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} FETCH_STATE;

endpackage

// File: rtl/fetch_stage_buf.sv
// Staging buffer for one fetched block; drains oldest-first into the instruction buffer.
module fetch_stage_buf import fetch_unit_pkg::*; #(
  parameter int unsigned DEPTH       = INST_BUFF_DEPTH,
  parameter int unsigned FETCH_WIDTH = fetch_unit_pkg::FETCH_WIDTH,
  parameter int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic                          load,
  input  logic [32*FETCH_WIDTH-1:0]     load_data,
  input  logic [CNT_W-1:0]              load_off,
  input  logic [31:0]                   load_pc,
  input  logic                          drain_en,
  input  logic [CNT_W-1:0]              open_entries,
  output logic [CNT_W-1:0]              count,
  output logic [CNT_W-1:0]              num_accept,
  output INST_PACKET [DEPTH-1:0]        insts
);

  // Staged instructions are kept shifted down so the oldest always sits at bits [31:0].
  logic [32*FETCH_WIDTH-1:0] blk_q, blk_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [31:0]               pc_q, pc_d;

  assign count = cnt_q;

  always_comb begin
    num_accept = (cnt_q < open_entries) ? cnt_q : open_entries;
    if (!drain_en) num_accept = '0;
  end

  for (genvar j = 0; j < DEPTH; j++) begin : g_slot
    if (j < FETCH_WIDTH) begin : g_live
      assign insts[j] = (num_accept > CNT_W'(j)) ?
          '{inst:  blk_q[32*j +: 32],
            PC:    pc_q + 32'(4 * j),
            NPC:   pc_q + 32'(4 * j + 4),
            valid: 1'b1} : '0;
    end else begin : g_idle
      assign insts[j] = '0;
    end
  end

  always_comb begin
    blk_d = blk_q;
    cnt_d = cnt_q;
    pc_d  = pc_q;
    if (clear) begin
      blk_d = '0;
      cnt_d = '0;
      pc_d  = '0;
    end else if (load) begin
      blk_d = load_data >> (32 * load_off);
      cnt_d = CNT_W'(FETCH_WIDTH) - load_off;
      pc_d  = load_pc;
    end else begin
      blk_d = blk_q >> (32 * num_accept);
      cnt_d = cnt_q - num_accept;
      pc_d  = pc_q + (32'(num_accept) << 2);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blk_q <= '0;
      cnt_q <= '0;
      pc_q  <= '0;
    end else begin
      blk_q <= blk_d;
      cnt_q <= cnt_d;
      pc_q  <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: requests instruction blocks, stages the response, pushes packets into the buffer.
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int unsigned DEPTH       = INST_BUFF_DEPTH,
  parameter int unsigned FETCH_WIDTH = fetch_unit_pkg::FETCH_WIDTH,
  parameter int unsigned TAG_W       = MEM_TAG_W,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          br_en,
  input  logic [31:0]                   br_target,
  input  logic [$clog2(DEPTH+1)-1:0]    open_entries,
  output logic                          mem_req_valid,
  output logic [31:0]                   mem_req_addr,
  output logic [TAG_W-1:0]              mem_req_tag,
  input  logic                          mem_req_ready,
  input  logic                          mem_resp_valid,
  input  logic [TAG_W-1:0]              mem_resp_tag,
  input  logic [32*FETCH_WIDTH-1:0]     mem_resp_data,
  output INST_PACKET [DEPTH-1:0]        in_insts,
  output logic [$clog2(DEPTH+1)-1:0]    num_accept
);

  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
  localparam logic [31:0] BLK_MASK = ~32'(4 * FETCH_WIDTH - 1);

  FETCH_STATE       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] pc_off, buf_cnt;
  logic             resp_hit, load;

  assign pc_off   = CNT_W'((pc_q >> 2) & 32'(FETCH_WIDTH - 1));
  assign resp_hit = mem_resp_valid && (mem_resp_tag == tag_q);

  assign mem_req_addr  = pc_q & BLK_MASK;
  assign mem_req_tag   = tag_q;
  // Gated by reset_n so the request drops while reset is held, not just at the next edge.
  assign mem_req_valid = reset_n && (state_q == IDLE) && !br_en;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tag_d   = tag_q;
    load    = 1'b0;
    if (br_en) begin
      state_d = IDLE;
      pc_d    = br_target;
      tag_d   = tag_q + 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (mem_req_ready) state_d = WAIT;
        WAIT: begin
          if (resp_hit) begin
            load    = 1'b1;
            pc_d    = (pc_q & BLK_MASK) + 32'(4 * FETCH_WIDTH);
            state_d = HOLD;
          end
        end
        HOLD: if (buf_cnt == num_accept) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tag_q   <= tag_d;
    end
  end

  fetch_stage_buf #(
    .DEPTH       (DEPTH),
    .FETCH_WIDTH (FETCH_WIDTH),
    .CNT_W       (CNT_W)
  ) u_stage_buf (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear        (br_en),
    .load         (load),
    .load_data    (mem_resp_data),
    .load_off     (pc_off),
    .load_pc      (pc_q),
    .drain_en     (!br_en),
    .open_entries (open_entries),
    .count        (buf_cnt),
    .num_accept   (num_accept),
    .insts        (in_insts)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed cycle-by-cycle vectors plus an asynchronous-reset sequence for fetch_unit.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned DEPTH = 8;

  localparam logic [31:0] IA = 32'hA000_0001, IB = 32'hB000_0002, IC = 32'hC000_0003;
  localparam logic [31:0] ID = 32'hD000_0004, IE = 32'hE000_0005, IF = 32'hF000_0006;
  localparam logic [31:0] IG = 32'h1234_0007, IH = 32'h5678_0008, II = 32'h9ABC_0009;
  localparam logic [31:0] IJ = 32'hDEF0_000A, IK = 32'h0BAD_000B, IL = 32'hCAFE_000C;
  localparam logic [31:0] IX = 32'hBAD0_BAD0;

  logic                   clock, reset_n, br_en, mem_req_ready, mem_resp_valid;
  logic [31:0]            br_target, mem_req_addr;
  logic [3:0]             open_entries, num_accept, mem_req_tag, mem_resp_tag;
  logic                   mem_req_valid;
  logic [63:0]            mem_resp_data;
  INST_PACKET [DEPTH-1:0] in_insts;

  fetch_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .br_en          (br_en),
    .br_target      (br_target),
    .open_entries   (open_entries),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_tag   (mem_resp_tag),
    .mem_resp_data  (mem_resp_data),
    .in_insts       (in_insts),
    .num_accept     (num_accept)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic [3:0]  open;
    logic        rdy;
    logic        rv;
    logic [3:0]  rtag;
    logic [63:0] rdata;
    logic        ev;
    logic [31:0] eaddr;
    logic [3:0]  etag;
    logic [3:0]  enm;
    logic [31:0] epc0, ei0, epc1, ei1;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic br, input logic [31:0] tgt, input logic [3:0] open,
                     input logic rdy, input logic rv, input logic [3:0] rtag,
                     input logic [63:0] rdata, input logic ev, input logic [31:0] eaddr,
                     input logic [3:0] etag, input logic [3:0] enm, input logic [31:0] epc0,
                     input logic [31:0] ei0, input logic [31:0] epc1, input logic [31:0] ei1);
    vec_t v;
    v = '{br, tgt, open, rdy, rv, rtag, rdata, ev, eaddr, etag, enm, epc0, ei0, epc1, ei1};
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    br_en = 1'b0; br_target = '0; open_entries = 4'd8; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_tag = '0; mem_resp_data = '0;
  endtask

  task automatic chk_slot(input string pfx, input int s, input logic on,
                          input logic [31:0] pc, input logic [31:0] inst);
    if (on) begin
      chk({pfx, $sformatf(" slot%0d inst", s)}, 128'(in_insts[s].inst), 128'(inst));
      chk({pfx, $sformatf(" slot%0d pc", s)}, 128'(in_insts[s].PC), 128'(pc));
      chk({pfx, $sformatf(" slot%0d npc", s)}, 128'(in_insts[s].NPC), 128'(pc + 32'd4));
      chk({pfx, $sformatf(" slot%0d valid", s)}, 128'(in_insts[s].valid), 128'(1'b1));
    end else begin
      chk({pfx, $sformatf(" slot%0d zero", s)}, 128'(in_insts[s]), 128'(0));
    end
  endtask

  initial begin
    vec_t v;
    string p;
    reset_n = 1'b0;
    idle_inputs();
    #2;
    chk("reset req_valid", 128'(mem_req_valid), 128'(0));
    chk("reset num_accept", 128'(num_accept), 128'(0));
    chk("reset in_insts", 128'(|in_insts), 128'(0));

    //  br tgt   open rdy rv rtag data         ev addr   tag num pc0    i0  pc1    i1
    add(0, 0,     8, 1, 0, 0, 0,            1, 32'h0,  0, 0, 0,     0,  0,     0);
    add(0, 0,     8, 0, 0, 0, 0,            0, 0,      0, 0, 0,     0,  0,     0);
    add(0, 0,     8, 0, 1, 0, {IB, IA},     0, 0,      0, 0, 0,     0,  0,     0);
    add(0, 0,     8, 0, 0, 0, 0,            0, 0,      0, 2, 32'h0, IA, 32'h4, IB);
    add(0, 0,     8, 0, 0, 0, 0,            1, 32'h8,  0, 0, 0,     0,  0,     0);
    add(0, 0,     8, 0, 0, 0, 0,            1, 32'h8,  0, 0, 0,     0,  0,     0);
    add(0, 0,     8, 0, 0, 0, 0,            1, 32'h8,  0, 0, 0,     0,  0,     0);
    add(0, 0,     8, 1, 0, 0, 0,            1, 32'h8,  0, 0, 0,     0,  0,     0);
    add(0, 0,     8, 0, 1, 0, {ID, IC},     0, 0,      0, 0, 0,     0,  0,     0);
    add(0, 0,     1, 0, 0, 0, 0,            0, 0,      0, 1, 32'h8, IC, 0,     0);
    add(0, 0,     0, 0, 0, 0, 0,            0, 0,      0, 0, 0,     0,  0,     0);
    add(0, 0,     2, 0, 0, 0, 0,            0, 0,      0, 1, 32'hC, ID, 0,     0);
    add(1, 32'h14, 8, 0, 0, 0, 0,           0, 0,      0, 0, 0,     0,  0,     0);
    add(0, 0,     8, 1, 0, 0, 0,            1, 32'h10, 1, 0, 0,     0,  0,     0);
    add(0, 0,     8, 0, 1, 1, {IF, IE},     0, 0,      0, 0, 0,     0,  0,     0);
    add(0, 0,     8, 0, 0, 0, 0,            0, 0,      0, 1, 32'h14, IF, 0,    0);
    add(0, 0,     8, 1, 0, 0, 0,            1, 32'h18, 1, 0, 0,     0,  0,     0);
    add(1, 32'h40, 8, 0, 1, 1, {IX, IX},    0, 0,      0, 0, 0,     0,  0,     0);
    add(0, 0,     8, 1, 0, 0, 0,            1, 32'h40, 2, 0, 0,     0,  0,     0);
    add(0, 0,     8, 0, 1, 1, {IX, IX},     0, 0,      0, 0, 0,     0,  0,     0);
    add(0, 0,     8, 0, 1, 2, {IH, IG},     0, 0,      0, 0, 0,     0,  0,     0);
    add(0, 0,     8, 0, 0, 0, 0,            0, 0,      0, 2, 32'h40, IG, 32'h44, IH);
    add(0, 0,     8, 1, 0, 0, 0,            1, 32'h48, 2, 0, 0,     0,  0,     0);
    add(0, 0,     8, 0, 1, 2, {IJ, II},     0, 0,      0, 0, 0,     0,  0,     0);
    add(1, 32'h100, 8, 0, 0, 0, 0,          0, 0,      0, 0, 0,     0,  0,     0);
    add(0, 0,     8, 0, 0, 0, 0,            1, 32'h100, 3, 0, 0,    0,  0,     0);
    add(0, 0,     8, 0, 0, 0, 0,            1, 32'h100, 3, 0, 0,    0,  0,     0);

    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vq[i]) begin
      v = vq[i];
      p = $sformatf("v%0d", i);
      br_en = v.br; br_target = v.tgt; open_entries = v.open; mem_req_ready = v.rdy;
      mem_resp_valid = v.rv; mem_resp_tag = v.rtag; mem_resp_data = v.rdata;
      #1;
      chk({p, " req_valid"}, 128'(mem_req_valid), 128'(v.ev));
      if (v.ev) begin
        chk({p, " req_addr"}, 128'(mem_req_addr), 128'(v.eaddr));
        chk({p, " req_tag"}, 128'(mem_req_tag), 128'(v.etag));
      end
      chk({p, " num_accept"}, 128'(num_accept), 128'(v.enm));
      chk_slot(p, 0, v.enm >= 4'd1, v.epc0, v.ei0);
      chk_slot(p, 1, v.enm >= 4'd2, v.epc1, v.ei1);
      chk({p, " upper slots"}, 128'(|in_insts[DEPTH-1:2]), 128'(0));
      @(negedge clock);
    end

    // Stage a full block, then pull reset mid-cycle while it is draining.
    idle_inputs();
    mem_req_ready = 1'b1;
    #1;
    chk("ar req_valid", 128'(mem_req_valid), 128'(1));
    chk("ar req_tag", 128'(mem_req_tag), 128'(3));
    @(negedge clock);
    idle_inputs();
    mem_resp_valid = 1'b1; mem_resp_tag = 4'd3; mem_resp_data = {IL, IK};
    @(negedge clock);
    idle_inputs();
    open_entries = 4'd0;
    #1;
    chk("ar held num", 128'(num_accept), 128'(0));
    @(negedge clock);
    open_entries = 4'd8;
    #1;
    chk("ar pre num", 128'(num_accept), 128'(2));
    chk_slot("ar pre", 0, 1'b1, 32'h100, IK);
    chk_slot("ar pre", 1, 1'b1, 32'h104, IL);
    #1;
    reset_n = 1'b0;
    #1;
    chk("ar num", 128'(num_accept), 128'(0));
    chk("ar insts", 128'(|in_insts), 128'(0));
    chk("ar req_valid off", 128'(mem_req_valid), 128'(0));
    @(negedge clock);
    reset_n = 1'b1;
    mem_req_ready = 1'b1;
    #1;
    chk("post req_valid", 128'(mem_req_valid), 128'(1));
    chk("post req_addr", 128'(mem_req_addr), 128'(0));
    chk("post req_tag", 128'(mem_req_tag), 128'(0));
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
